mips_mc: RTL and testbench

MIPS_MC -- requirements
Module: mips_mc

---
 rtl/mips_mc_pkg.sv | 23 ++
 rtl/mips_mc_rf.sv | 27 ++
 rtl/mips_mc.sv | 181 ++++++++++++++++++
 tb/tb_mips_mc.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared encodings, FSM states and ALU ops for the mips_mc core
package mips_mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   typedef enum logic [2:0] {FETCH, DECODE, EXE, MEM, WB, TRAP} state_t;

   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_LUI} alu_op_t;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/mips_mc_rf.sv
// rtl/mips_mc_rf.sv - 32x32 register file, two async read ports, one sync write port
// Register 0 is hardwired to zero on read and never written.
module mips_mc_rf (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);
   logic [31:0] regs [32];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && wa != 5'd0) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];

endmodule

// File: rtl/mips_mc.sv
// rtl/mips_mc.sv - multi-cycle MIPS subset core sharing one memory port for fetch and data
// Optional retire trace port enabled by defining MIPS_MC_TRACE_EN.
module mips_mc
   import mips_mc_pkg::*;
#(
   parameter int          ADDR_W   = 12,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic [31:0]       pc,
   output logic              err
`ifdef MIPS_MC_TRACE_EN
   ,
   output logic              tr_valid,
   output logic [31:0]       tr_pc,
   output logic [31:0]       tr_instr
`endif
);
   state_t      state;
   alu_op_t     alu_op;
   logic [31:0] ir, a, b, result;
   logic [31:0] rd1, rd2, simm, pc4, npc, ea, alu_y;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic        legal, is_r, is_lw, is_sw, is_beq, is_j, retire, rf_we;
   logic        unused;

   assign opcode = ir[31:26];
   assign rs     = ir[25:21];
   assign rt     = ir[20:16];
   assign rd     = ir[15:11];
   assign funct  = ir[5:0];
   assign imm    = ir[15:0];
   assign simm   = sext16(imm);
   assign is_r   = (opcode == OP_RTYPE);
   assign is_lw  = (opcode == OP_LW);
   assign is_sw  = (opcode == OP_SW);
   assign is_beq = (opcode == OP_BEQ);
   assign is_j   = (opcode == OP_J);
   assign pc4    = pc + 32'd4;
   assign ea     = a + simm;
   assign unused = ^{ir[10:6], ea[31:ADDR_W]};

   always_comb begin
      legal  = 1'b1;
      alu_op = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            if (funct == FN_ADDU)      alu_op = ALU_ADD;
            else if (funct == FN_SUBU) alu_op = ALU_SUB;
            else                       legal  = 1'b0;
         end
         OP_ORI:                     alu_op = ALU_OR;
         OP_LUI:                     alu_op = ALU_LUI;
         OP_LW, OP_SW, OP_BEQ, OP_J: alu_op = ALU_ADD;
         default:                    legal  = 1'b0;
      endcase
   end

   always_comb begin
      case (alu_op)
         ALU_ADD: alu_y = a + b;
         ALU_SUB: alu_y = a - b;
         ALU_OR:  alu_y = a | {16'h0, imm};
         default: alu_y = {imm, 16'h0};
      endcase
   end

   always_comb begin
      npc = pc4;
      if (is_j)                 npc = {pc4[31:28], ir[25:0], 2'b00};
      else if (is_beq && a == b) npc = pc4 + {simm[29:0], 2'b00};
   end

   // Final state of each instruction class; next fetch request starts on the same edge.
   assign retire = (state == WB)
                || (state == EXE && (is_beq || is_j))
                || (state == MEM && mem_ack && is_sw);
   assign rf_we  = (state == WB);

   mips_mc_rf u_rf (
      .clk (clk),
      .rst (rst),
      .ra1 (rs),
      .ra2 (rt),
      .rd1 (rd1),
      .rd2 (rd2),
      .we  (rf_we),
      .wa  (is_r ? rd : rt),
      .wd  (result)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         err       <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ir        <= '0;
         a         <= '0;
         b         <= '0;
         result    <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {pc[ADDR_W-1:2], 2'b00};
               end else if (mem_ack) begin
                  ir      <= mem_rdata;
                  mem_req <= 1'b0;
                  state   <= DECODE;
               end
            end
            DECODE: begin
               if (!legal) begin
                  err   <= 1'b1;
                  state <= TRAP;
               end else begin
                  a     <= rd1;
                  b     <= rd2;
                  state <= EXE;
               end
            end
            EXE: begin
               if (is_lw || is_sw) begin
                  if (ea[1:0] != 2'b00) begin
                     err   <= 1'b1;
                     state <= TRAP;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= is_sw;
                     mem_addr  <= {ea[ADDR_W-1:2], 2'b00};
                     mem_wdata <= b;
                     state     <= MEM;
                  end
               end else if (!(is_beq || is_j)) begin
                  result <= alu_y;
                  state  <= WB;
               end
            end
            MEM: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  result  <= mem_rdata;
                  state   <= WB;
               end
            end
            default: ;
         endcase

         if (retire) begin
            pc       <= npc;
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {npc[ADDR_W-1:2], 2'b00};
         end
      end
   end

`ifdef MIPS_MC_TRACE_EN
   assign tr_valid = retire;
   assign tr_pc    = pc;
   assign tr_instr = ir;
`endif

endmodule

// File: tb/tb_mips_mc.sv
// tb/tb_mips_mc.sv - scoreboard bench for mips_mc bus traffic, timing, traps and reset
module tb_mips_mc;

   typedef struct {
      bit          fetch;
      bit          we;
      logic [11:0] addr;
      logic [31:0] data;
      int          gap;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req, mem_we, mem_ack, err;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata, pc;
`ifdef MIPS_MC_TRACE_EN
   logic        tr_valid;
   logic [31:0] tr_pc, tr_instr;
`endif

   txn_t        sb[$];
   logic [31:0] mem [0:1023];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          last_ack = 0;
   int          ack_delay = 0;
   bit          stray_ack = 1'b0;
   bit          checking = 1'b0;

   logic [31:0] trap_i0 [4] = '{32'h8C06_0002, 32'hFC00_0000, 32'h0022_1820, 32'h3401_0003};
   logic [31:0] trap_i1 [4] = '{32'h0, 32'h0, 32'h0, 32'hAC22_0000};
   logic [31:0] trap_pc [4] = '{32'h0, 32'h0, 32'h0, 32'h4};

   mips_mc #(.ADDR_W(12), .RESET_PC(32'h0)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .pc        (pc),
      .err       (err)
`ifdef MIPS_MC_TRACE_EN
      ,
      .tr_valid  (tr_valid),
      .tr_pc     (tr_pc),
      .tr_instr  (tr_instr)
`endif
   );

   initial forever #5 clk = ~clk;

   task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic push(input bit f, input bit w, input logic [11:0] ad, input logic [31:0] d, input int g);
      txn_t t;
      t.fetch = f; t.we = w; t.addr = ad; t.data = d; t.gap = g;
      sb.push_back(t);
   endtask

   // Memory responder: acks after ack_delay wait cycles; optional stray acks when idle.
   initial begin : responder
      int waited;
      waited    = 0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (rst && mem_req) begin
            if (waited >= ack_delay) begin
               mem_ack   = 1'b1;
               waited    = 0;
               mem_rdata = mem[mem_addr[11:2]];
               if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
            end else begin
               waited++;
            end
         end else begin
            waited = 0;
            if (stray_ack) begin
               mem_ack   = 1'b1;
               mem_rdata = 32'hDEAD_BEEF;
            end
         end
      end
   end

   initial begin : monitor
      txn_t e;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (checking && mem_req && mem_ack) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_access: got we=%b addr=%h, want no access", mem_we, mem_addr);
            end else begin
               e = sb.pop_front();
               vectors++;
               if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)
                   || (e.fetch && pc !== {20'h0, e.addr}) || (e.gap >= 0 && cyc - last_ack != e.gap)) begin
                  miscompares++;
                  $display("FAIL access: got we=%b addr=%h wdata=%h pc=%h gap=%0d, want we=%b addr=%h wdata=%h gap=%0d",
                           mem_we, mem_addr, mem_wdata, pc, cyc - last_ack, e.we, e.addr, e.data, e.gap);
               end
            end
            last_ack = cyc;
         end
      end
   end

`ifdef MIPS_MC_TRACE_EN
   initial begin : trace_mon
      forever begin
         @(negedge clk);
         #1;
         if (checking && tr_valid) check1("trace_instr", tr_instr, mem[tr_pc[11:2]]);
      end
   end
`endif

   task automatic reset_enter();
      @(negedge clk);
      checking = 1'b0;
      rst = 1'b0;
      #1;
      check1("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check1("rst_err", {31'h0, err}, 32'h0);
      check1("rst_pc", pc, 32'h0);
      check1("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
      sb.delete();
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
   endtask

   task automatic reset_release(input int d, input bit stray);
      ack_delay = d;
      stray_ack = stray;
      @(negedge clk);
      rst = 1'b1;
      checking = 1'b1;
      @(posedge clk);
      #1;
      check1("first_req", {31'h0, mem_req}, 32'h1);
      check1("first_addr", {20'h0, mem_addr}, 32'h0);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      check1("drain_pending", 32'(sb.size()), 32'h0);
      sb.delete();
   endtask

   initial begin : stim
      // ALU ops, $0 discard, stores exposing results, beq self-loop; immediate acks
      reset_enter();
      mem[0]  = 32'h3401_1234;   // ori  $1,$0,0x1234
      mem[1]  = 32'h3C02_8000;   // lui  $2,0x8000
      mem[2]  = 32'h0042_1821;   // addu $3,$2,$2
      mem[3]  = 32'h0001_2023;   // subu $4,$0,$1
      mem[4]  = 32'hAC03_0200;   // sw   $3,0x200($0)
      mem[5]  = 32'hAC04_0204;   // sw   $4,0x204($0)
      mem[6]  = 32'h0021_0021;   // addu $0,$1,$1
      mem[7]  = 32'hAC00_0208;   // sw   $0,0x208($0)
      mem[8]  = 32'hAC02_020C;   // sw   $2,0x20C($0)
      mem[9]  = 32'h1000_FFFF;   // beq  $0,$0,-1
      push(1, 0, 12'h000, 0, -1);
      push(1, 0, 12'h004, 0, 4);
      push(1, 0, 12'h008, 0, 4);
      push(1, 0, 12'h00C, 0, 4);
      push(1, 0, 12'h010, 0, 4);
      push(0, 1, 12'h200, 32'h0000_0000, 3);
      push(1, 0, 12'h014, 0, 1);
      push(0, 1, 12'h204, 32'hFFFF_EDCC, 3);
      push(1, 0, 12'h018, 0, 1);
      push(1, 0, 12'h01C, 0, 4);
      push(0, 1, 12'h208, 32'h0000_0000, 3);
      push(1, 0, 12'h020, 0, 1);
      push(0, 1, 12'h20C, 32'h8000_0000, 3);
      push(1, 0, 12'h024, 0, 1);
      push(1, 0, 12'h024, 0, 3);
      push(1, 0, 12'h024, 0, 3);
      reset_release(0, 1'b1);
      drain(300);

      // jump, sw/lw through memory with 3 wait cycles, beq taken/not taken, j self-loop
      reset_enter();
      mem[0]   = 32'h3401_1234;  // ori  $1,$0,0x1234
      mem[1]   = 32'h0800_0040;  // j    0x40 -> 0x100
      mem[64]  = 32'hAC01_0008;  // sw   $1,8($0)
      mem[65]  = 32'h8C05_0008;  // lw   $5,8($0)
      mem[66]  = 32'hAC05_0210;  // sw   $5,0x210($0)
      mem[67]  = 32'h1025_0002;  // beq  $1,$5,2 -> 0x118
      mem[68]  = 32'hFFFF_FFFF;
      mem[70]  = 32'h1001_0005;  // beq  $0,$1,5 (not taken)
      mem[71]  = 32'h0800_0047;  // j    0x47 -> 0x11C
      push(1, 0, 12'h000, 0, -1);
      push(1, 0, 12'h004, 0, 7);
      push(1, 0, 12'h100, 0, 6);
      push(0, 1, 12'h008, 32'h0000_1234, 6);
      push(1, 0, 12'h104, 0, 4);
      push(0, 0, 12'h008, 0, 6);
      push(1, 0, 12'h108, 0, 5);
      push(0, 1, 12'h210, 32'h0000_1234, 6);
      push(1, 0, 12'h10C, 0, 4);
      push(1, 0, 12'h118, 0, 6);
      push(1, 0, 12'h11C, 0, 6);
      push(1, 0, 12'h11C, 0, 6);
      reset_release(3, 1'b0);
      drain(600);

      // traps: misaligned lw, opcode 0x3F, bad funct, misaligned sw at pc 4
      for (int k = 0; k < 4; k++) begin
         reset_enter();
         mem[0] = trap_i0[k];
         mem[1] = trap_i1[k];
         push(1, 0, 12'h000, 0, -1);
         if (trap_pc[k] != 32'h0) push(1, 0, 12'h004, 0, 5);
         reset_release(1, 1'b1);
         drain(100);
         repeat (8) @(negedge clk);
         #1;
         check1("trap_err", {31'h0, err}, 32'h1);
         check1("trap_pc", pc, trap_pc[k]);
         check1("trap_mem_req", {31'h0, mem_req}, 32'h0);
      end

      reset_enter();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
